// File: rtl/game_flow_ctrl_if.sv
// Control bundle between the game-flow controller and the rest of the puzzle design.
// The slave side is the controller; the master side drives buttons/engine status.
interface game_flow_ctrl_if #(
  parameter int N_LEVELS = 3
);
  logic [N_LEVELS-1:0] level_req;
  logic                move;
  logic                win;
  logic                lose;
  logic                draw_done;
  logic                clear;
  logic                draw_grid;
  logic [N_LEVELS-1:0] draw_level;
  logic                draw_num;
  logic                in_game;
  logic                game_over;
  logic                won;
  logic [N_LEVELS-1:0] level_sel;
  logic                draw_timeout;
  logic [3:0]          state_dbg;

  modport master (
    output level_req, move, win, lose, draw_done,
    input  clear, draw_grid, draw_level, draw_num, in_game, game_over,
           won, level_sel, draw_timeout, state_dbg
  );

  modport slave (
    input  level_req, move, win, lose, draw_done,
    output clear, draw_grid, draw_level, draw_num, in_game, game_over,
           won, level_sel, draw_timeout, state_dbg
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer for the sliding-puzzle VGA design: clear, grid, level select,
// banner, play, per-move redraw and game-over, with fixed-length or handshake phases.
module game_flow_ctrl #(
  parameter int N_LEVELS    = 3,
  parameter int CNT_W       = 16,
  parameter int DRAW_TICKS  = 3200,
  parameter int CLEAR_TICKS = 16000,
  parameter int USE_DONE    = 1
) (
  input logic              clk,
  input logic              resetn,
  game_flow_ctrl_if.slave  ctrl_io
);

  typedef enum logic [3:0] {
    S_CLEAR  = 4'd0,
    S_GRID   = 4'd1,
    S_SELECT = 4'd2,
    S_LEVEL  = 4'd3,
    S_ARM    = 4'd4,
    S_PLAY   = 4'd5,
    S_NUM    = 4'd6,
    S_OVER   = 4'd7
  } state_e;

  localparam logic [CNT_W-1:0]    CLEAR_LAST = CNT_W'(CLEAR_TICKS - 1);
  localparam logic [CNT_W-1:0]    DRAW_LAST  = CNT_W'(DRAW_TICKS - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [N_LEVELS-1:0] REQ_ONE    = N_LEVELS'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_LEVELS-1:0] level_sel_q, level_sel_d;
  logic                won_q, won_d;
  logic                timeout_q, timeout_d;

  logic [CNT_W-1:0]    lim_last;
  logic                tick_end, done_ok, phase_end, is_phase, req_one_hot, req_none;

  always_comb begin
    state_d     = state_q;
    level_sel_d = level_sel_q;
    won_d       = won_q;
    timeout_d   = 1'b0;

    lim_last    = (state_q == S_CLEAR) ? CLEAR_LAST : DRAW_LAST;
    // >= rather than == so a NUM phase held past its limit still ends on release
    tick_end    = (cnt_q >= lim_last);
    done_ok     = (USE_DONE != 0) && ctrl_io.draw_done && (cnt_q != '0);
    phase_end   = tick_end || done_ok;
    is_phase    = (state_q == S_CLEAR) || (state_q == S_GRID) ||
                  (state_q == S_LEVEL) || (state_q == S_NUM);
    req_none    = (ctrl_io.level_req == '0);
    req_one_hot = !req_none && ((ctrl_io.level_req & (ctrl_io.level_req - REQ_ONE)) == '0);

    case (state_q)
      S_CLEAR:  if (phase_end) state_d = S_GRID;
      S_GRID:   if (phase_end) state_d = S_SELECT;
      S_SELECT: if (req_one_hot) begin
                  state_d     = S_LEVEL;
                  level_sel_d = ctrl_io.level_req;
                end
      S_LEVEL:  if (phase_end) state_d = S_ARM;
      S_ARM:    if (req_none) state_d = S_NUM;
      S_NUM:    if (phase_end && req_none) state_d = S_PLAY;
      S_PLAY:   begin
                  if (ctrl_io.win || ctrl_io.lose) begin
                    state_d = S_OVER;
                    won_d   = ctrl_io.win;
                  end else if (!req_none) begin
                    state_d = S_CLEAR;
                  end else if (ctrl_io.move) begin
                    state_d = S_NUM;
                  end
                end
      S_OVER:   if (!req_none) state_d = S_CLEAR;
      default:  state_d = S_CLEAR;
    endcase

    if ((USE_DONE != 0) && is_phase && (state_d != state_q) && tick_end && !done_ok)
      timeout_d = 1'b1;

    if (state_d != state_q) cnt_d = '0;
    else if (&cnt_q)        cnt_d = cnt_q;
    else                    cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      level_sel_q <= '0;
      won_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_sel_q <= level_sel_d;
      won_q       <= won_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ctrl_io.clear        = (state_q == S_CLEAR);
  assign ctrl_io.draw_grid    = (state_q == S_GRID);
  assign ctrl_io.draw_level   = (state_q == S_LEVEL) ? level_sel_q : '0;
  assign ctrl_io.draw_num     = (state_q == S_NUM);
  assign ctrl_io.in_game      = (state_q == S_PLAY);
  assign ctrl_io.game_over    = (state_q == S_OVER);
  assign ctrl_io.won          = won_q;
  assign ctrl_io.level_sel    = level_sel_q;
  assign ctrl_io.draw_timeout = timeout_q;
  assign ctrl_io.state_dbg    = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: one fixed-duration instance and one handshake instance,
// randomized play sessions checked against a phase-length / result model.
module tb_game_flow_ctrl;
  localparam int N  = 3;
  localparam int DT = 8;
  localparam int CT = 16;
  localparam logic [3:0] ST_CLEAR = 4'd0, ST_GRID = 4'd1, ST_SELECT = 4'd2, ST_LEVEL = 4'd3,
                         ST_ARM = 4'd4, ST_PLAY = 4'd5, ST_NUM = 4'd6, ST_OVER = 4'd7;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  game_flow_ctrl_if #(.N_LEVELS(N)) if0 ();
  game_flow_ctrl_if #(.N_LEVELS(N)) if1 ();

  game_flow_ctrl #(.N_LEVELS(N), .CNT_W(16), .DRAW_TICKS(DT), .CLEAR_TICKS(CT), .USE_DONE(0))
    u_dut0 (.clk(clk), .resetn(resetn), .ctrl_io(if0));
  game_flow_ctrl #(.N_LEVELS(N), .CNT_W(16), .DRAW_TICKS(DT), .CLEAR_TICKS(CT), .USE_DONE(1))
    u_dut1 (.clk(clk), .resetn(resetn), .ctrl_io(if1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    logic r;
    r = 1'b0;
    case (sel)
      0:  r = if0.clear;
      1:  r = if0.draw_grid;
      2:  r = |if0.draw_level;
      3:  r = if0.draw_num;
      10: r = if1.clear;
      11: r = if1.draw_grid;
      12: r = |if1.draw_level;
      13: r = if1.draw_num;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Counts consecutive cycles (from the current sample) that the selected output is high.
  task automatic count_high(input int sel, output int n);
    n = 0;
    while (sig(sel) && n < 64) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    checks++; if (if0.state_dbg !== ST_CLEAR) begin errors++; $display("FAIL reset_state got %0d want %0d", if0.state_dbg, ST_CLEAR); end
    checks++; if (if0.clear !== 1'b1) begin errors++; $display("FAIL reset_clear got %b want 1", if0.clear); end
    checks++; if ({if0.draw_grid, if0.draw_level, if0.draw_num, if0.in_game, if0.game_over} !== 7'd0)
      begin errors++; $display("FAIL reset_outs got %b want 0", {if0.draw_grid, if0.draw_level, if0.draw_num, if0.in_game, if0.game_over}); end
    checks++; if ({if0.level_sel, if0.won, if0.draw_timeout} !== 5'd0)
      begin errors++; $display("FAIL reset_regs got %b want 0", {if0.level_sel, if0.won, if0.draw_timeout}); end
    resetn = 1'b1;
  endtask

  task automatic test_boot();
    int n;
    count_high(0, n);
    checks++; if (n !== CT) begin errors++; $display("FAIL boot_clear_len got %0d want %0d", n, CT); end
    count_high(1, n);
    checks++; if (n !== DT) begin errors++; $display("FAIL boot_grid_len got %0d want %0d", n, DT); end
    checks++; if (if0.state_dbg !== ST_SELECT) begin errors++; $display("FAIL boot_select got %0d want %0d", if0.state_dbg, ST_SELECT); end
    checks++; if ({if0.clear, if0.draw_grid, if0.draw_level, if0.draw_num} !== 6'd0)
      begin errors++; $display("FAIL boot_draw_idle got %b want 0", {if0.clear, if0.draw_grid, if0.draw_level, if0.draw_num}); end
  endtask

  task automatic test_select();
    int n;
    if0.level_req = 3'b011;
    repeat (3) tick();
    checks++; if (if0.state_dbg !== ST_SELECT || if0.level_sel !== 3'b000)
      begin errors++; $display("FAIL multihot_ignored got st=%0d sel=%b want st=%0d sel=000", if0.state_dbg, if0.level_sel, ST_SELECT); end
    if0.level_req = 3'b100;
    tick();
    checks++; if (if0.level_sel !== 3'b100 || if0.draw_level !== 3'b100)
      begin errors++; $display("FAIL select_load got sel=%b dl=%b want 100", if0.level_sel, if0.draw_level); end
    count_high(2, n);
    checks++; if (n !== DT) begin errors++; $display("FAIL level_len got %0d want %0d", n, DT); end
    repeat (4) tick();
    checks++; if (if0.state_dbg !== ST_ARM) begin errors++; $display("FAIL arm_hold got %0d want %0d", if0.state_dbg, ST_ARM); end
    if0.level_req = '0;
    tick();
    count_high(3, n);
    checks++; if (n !== DT) begin errors++; $display("FAIL init_num_len got %0d want %0d", n, DT); end
    checks++; if (if0.in_game !== 1'b1) begin errors++; $display("FAIL enter_play got %b want 1", if0.in_game); end
  endtask

  // From CLEAR back to SELECT; level_sel and won must be held from the previous game.
  task automatic restart_to_select(input logic [N-1:0] lvl_exp, input logic won_exp);
    int n;
    count_high(0, n);
    checks++; if (n !== CT) begin errors++; $display("FAIL restart_clear_len got %0d want %0d", n, CT); end
    count_high(1, n);
    checks++; if (n !== DT) begin errors++; $display("FAIL restart_grid_len got %0d want %0d", n, DT); end
    checks++; if (if0.state_dbg !== ST_SELECT || if0.level_sel !== lvl_exp || if0.won !== won_exp)
      begin errors++; $display("FAIL restart_held got st=%0d sel=%b won=%b want st=%0d sel=%b won=%b",
                               if0.state_dbg, if0.level_sel, if0.won, ST_SELECT, lvl_exp, won_exp); end
  endtask

  task automatic select_to_play(output logic [N-1:0] lvl);
    int n;
    logic [N-1:0] bad [4];
    bad[0] = 3'b011; bad[1] = 3'b101; bad[2] = 3'b110; bad[3] = 3'b111;
    if0.level_req = bad[$urandom_range(0, 3)];
    tick();
    checks++; if (if0.state_dbg !== ST_SELECT) begin errors++; $display("FAIL rand_multihot got %0d want %0d", if0.state_dbg, ST_SELECT); end
    lvl = N'(1) << $urandom_range(0, N - 1);
    if0.level_req = lvl;
    tick();
    checks++; if (if0.draw_level !== lvl || if0.level_sel !== lvl)
      begin errors++; $display("FAIL rand_select got dl=%b sel=%b want %b", if0.draw_level, if0.level_sel, lvl); end
    count_high(2, n);
    checks++; if (n !== DT) begin errors++; $display("FAIL rand_level_len got %0d want %0d", n, DT); end
    if0.level_req = '0;
    tick();
    count_high(3, n);
    checks++; if (n !== DT || if0.in_game !== 1'b1)
      begin errors++; $display("FAIL rand_num_play got len=%0d play=%b want %0d 1", n, if0.in_game, DT); end
  endtask

  task automatic test_play_random();
    logic [N-1:0] lvl_exp = 3'b100;
    logic won_exp = 1'b0;
    logic w, l, m;
    int n, act, ending;
    for (int g = 0; g < 8; g++) begin
      repeat ($urandom_range(2, 6)) begin
        act = $urandom_range(0, 1);
        if (act == 0) begin
          tick();
          checks++; if (if0.state_dbg !== ST_PLAY) begin errors++; $display("FAIL play_idle got %0d want %0d", if0.state_dbg, ST_PLAY); end
        end else begin
          if0.move = 1'b1;
          tick();
          if0.move = 1'b0;
          count_high(3, n);
          checks++; if (n !== DT || if0.state_dbg !== ST_PLAY)
            begin errors++; $display("FAIL move_redraw got len=%0d st=%0d want %0d %0d", n, if0.state_dbg, DT, ST_PLAY); end
        end
      end
      ending = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 3 : $urandom_range(0, 4);
      if (ending == 3) begin
        if0.level_req = N'(1) << $urandom_range(0, N - 1);
        tick();
        if0.level_req = '0;
        checks++; if (if0.state_dbg !== ST_CLEAR) begin errors++; $display("FAIL abort got %0d want %0d", if0.state_dbg, ST_CLEAR); end
      end else begin
        w = (ending == 0) || (ending == 2) || (ending == 4);
        l = (ending == 1) || (ending == 2);
        m = (ending == 4) ? 1'b1 : 1'($urandom_range(0, 1));
        if0.win = w; if0.lose = l; if0.move = m;
        tick();
        won_exp = w;
        checks++; if (if0.game_over !== 1'b1 || if0.won !== won_exp)
          begin errors++; $display("FAIL game_end got over=%b won=%b want 1 %b", if0.game_over, if0.won, won_exp); end
        if0.win = 1'($urandom_range(0, 1)); if0.lose = ~if0.win; if0.move = 1'b1;
        tick();
        if0.win = 1'b0; if0.lose = 1'b0; if0.move = 1'b0;
        checks++; if (if0.state_dbg !== ST_OVER || if0.won !== won_exp)
          begin errors++; $display("FAIL over_ignore got st=%0d won=%b want %0d %b", if0.state_dbg, if0.won, ST_OVER, won_exp); end
        if0.level_req = N'($urandom_range(1, 7));
        tick();
        if0.level_req = '0;
        checks++; if (if0.state_dbg !== ST_CLEAR) begin errors++; $display("FAIL over_exit got %0d want %0d", if0.state_dbg, ST_CLEAR); end
      end
      restart_to_select(lvl_exp, won_exp);
      select_to_play(lvl_exp);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    if0.win = 1'b1;
    tick();
    if0.win = 1'b0;
    if0.level_req = 3'b001;
    tick();
    if0.level_req = '0;
    k = 0;
    while (if0.state_dbg !== ST_SELECT && k < 100) begin k++; tick(); end
    checks++; if (k >= 100) begin errors++; $display("FAIL wait_select got timeout want SELECT"); end
    if0.level_req = 3'b001;
    tick();
    repeat (3) tick();
    checks++; if (if0.state_dbg !== ST_LEVEL || if0.won !== 1'b1)
      begin errors++; $display("FAIL pre_reset got st=%0d won=%b want %0d 1", if0.state_dbg, if0.won, ST_LEVEL); end
    resetn = 1'b0; if0.draw_done = 1'b1; if1.draw_done = 1'b1;
    tick();
    resetn = 1'b1; if0.draw_done = 1'b0; if1.draw_done = 1'b0; if0.level_req = '0;
    checks++; if (if0.state_dbg !== ST_CLEAR || if0.clear !== 1'b1 || if0.level_sel !== 3'b000 || if0.won !== 1'b0 || if0.draw_level !== 3'b000)
      begin errors++; $display("FAIL mid_reset got st=%0d clr=%b sel=%b won=%b want %0d 1 000 0",
                               if0.state_dbg, if0.clear, if0.level_sel, if0.won, ST_CLEAR); end
  endtask

  task automatic test_handshake();
    int n;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    if1.draw_done = 1'b1;
    tick();
    if1.draw_done = 1'b0;
    checks++; if (if1.state_dbg !== ST_CLEAR) begin errors++; $display("FAIL entry_done_ignored got %0d want %0d", if1.state_dbg, ST_CLEAR); end
    tick();
    tick();
    if1.draw_done = 1'b1;
    tick();
    if1.draw_done = 1'b0;
    checks++; if (if1.state_dbg !== ST_GRID || if1.draw_timeout !== 1'b0)
      begin errors++; $display("FAIL done_exit got st=%0d to=%b want %0d 0", if1.state_dbg, if1.draw_timeout, ST_GRID); end
    count_high(11, n);
    checks++; if (n !== DT || if1.state_dbg !== ST_SELECT)
      begin errors++; $display("FAIL timeout_len got len=%0d st=%0d want %0d %0d", n, if1.state_dbg, DT, ST_SELECT); end
    checks++; if (if1.draw_timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse got %b want 1", if1.draw_timeout); end
    tick();
    checks++; if (if1.draw_timeout !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle got %b want 0", if1.draw_timeout); end
    if1.level_req = 3'b010;
    tick();
    repeat (DT - 1) tick();
    if1.draw_done = 1'b1;
    tick();
    if1.draw_done = 1'b0;
    checks++; if (if1.state_dbg !== ST_ARM || if1.draw_timeout !== 1'b0)
      begin errors++; $display("FAIL done_and_timeout got st=%0d to=%b want %0d 0", if1.state_dbg, if1.draw_timeout, ST_ARM); end
    if1.level_req = '0;
    tick();
    tick();
    tick();
    if1.draw_done = 1'b1;
    tick();
    if1.draw_done = 1'b0;
    checks++; if (if1.state_dbg !== ST_PLAY || if1.draw_timeout !== 1'b0)
      begin errors++; $display("FAIL num_done got st=%0d to=%b want %0d 0", if1.state_dbg, if1.draw_timeout, ST_PLAY); end
  endtask

  initial begin
    if0.level_req = '0; if0.move = 1'b0; if0.win = 1'b0; if0.lose = 1'b0; if0.draw_done = 1'b0;
    if1.level_req = '0; if1.move = 1'b0; if1.win = 1'b0; if1.lose = 1'b0; if1.draw_done = 1'b0;
    #2;
    test_reset();
    test_boot();
    test_select();
    test_play_random();
    test_reset_mid();
    test_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end
endmodule
